// File: rtl/digital_out_serializer_pkg.sv
// Shared constants for the digital top output path: ADC/sample widths,
// serializer FSM encoding and a constant-safe clog2 helper.
package digital_out_serializer_pkg;

    // ADC bit width, shared with the DFE/ADC-TEG chain and the selector.
    localparam int BW = 6;
    // Selector sample width.
    localparam int DW = BW + 15;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } ser_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/dout_fifo.sv
// Sync FIFO with registered read and occupancy count; a push into a full
// FIFO is accepted when a pop happens in the same cycle.
// Ports: clk, clear (sync flush), push/wdata, pop, rdata (valid cycle after
// pop), level (occupancy), drop (push lost because full and no pop).
module dout_fifo
    import digital_out_serializer_pkg::*;
#(
    parameter int W     = DW,
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  push,
    input  logic [W-1:0]          wdata,
    input  logic                  pop,
    output logic [W-1:0]          rdata,
    output logic [clog2(DEPTH):0] level,
    output logic                  drop
);

    localparam int AW = clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          full;
    logic          empty;
    logic          wr_ok;
    logic          rd_ok;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    // When full, wptr == rptr: the read sees the old word, the write lands after.
    assign wr_ok = push & (~full | pop);
    assign rd_ok = pop & ~empty;
    assign drop  = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr] <= wdata;
        if (rd_ok) rdata <= mem[rptr];
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
            level <= level + LW'(wr_ok) - LW'(rd_ok);
        end
    end

endmodule

// File: rtl/digital_out_serializer.sv
// Captures selector samples on IN_STROBE rises, buffers them and ships them
// MSB-first on SER_DATA with SER_FRAME and a trailing even-parity bit.
// Ports: CLK, RES (sync, active-low), IN_SAMPLE, IN_STROBE, ENABLE,
// SER_DATA, SER_FRAME, OVF (sticky drop flag), FIFO_LEVEL.
module digital_out_serializer
    import digital_out_serializer_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  RES,
    input  logic signed [DW-1:0]  IN_SAMPLE,
    input  logic                  IN_STROBE,
    input  logic                  ENABLE,
    output logic                  SER_DATA,
    output logic                  SER_FRAME,
    output logic                  OVF,
    output logic [clog2(DEPTH):0] FIFO_LEVEL
);

    localparam int CW = clog2(DW + 1);
    localparam int GW = clog2(GAP_CYCLES + 1);

    ser_state_t    state;
    ser_state_t    nxt;
    logic          strobe_d;
    logic          rise;
    logic          clear;
    logic          pop;
    logic          drop;
    logic [DW-1:0] rdata;
    logic [DW-1:0] shreg;
    logic          par;
    logic [CW-1:0] bitcnt;
    logic [GW-1:0] gap_cnt;
    logic          data_nxt;
    logic          frame_nxt;

    // ENABLE=0 behaves like reset, but the strobe history keeps tracking.
    assign clear = ~RES | ~ENABLE;
    assign rise  = IN_STROBE & ~strobe_d;

    always_ff @(posedge CLK) begin
        if (!RES) strobe_d <= 1'b0;
        else      strobe_d <= IN_STROBE;
    end

    dout_fifo #(
        .W     (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .clear (clear),
        .push  (rise),
        .wdata (IN_SAMPLE),
        .pop   (pop),
        .rdata (rdata),
        .level (FIFO_LEVEL),
        .drop  (drop)
    );

    always_ff @(posedge CLK) begin
        if (clear)     OVF <= 1'b0;
        else if (drop) OVF <= 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (clear) begin
            state     <= S_IDLE;
            SER_DATA  <= 1'b0;
            SER_FRAME <= 1'b0;
        end else begin
            state     <= nxt;
            SER_DATA  <= data_nxt;
            SER_FRAME <= frame_nxt;
        end
    end

    // shreg is pre-shifted so its MSB is always the next bit to drive;
    // bitcnt is the index of the bit currently on the pins.
    always_ff @(posedge CLK) begin
        if (clear) begin
            shreg   <= '0;
            par     <= 1'b0;
            bitcnt  <= '0;
            gap_cnt <= '0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    shreg  <= {rdata[DW-2:0], 1'b0};
                    par    <= ^rdata;
                    bitcnt <= '0;
                end
                S_SHIFT: begin
                    shreg   <= {shreg[DW-2:0], 1'b0};
                    bitcnt  <= bitcnt + 1'b1;
                    gap_cnt <= '0;
                end
                S_GAP:   gap_cnt <= gap_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:  if (FIFO_LEVEL != '0) nxt = S_LOAD;
            S_LOAD:  nxt = S_SHIFT;
            S_SHIFT: if (bitcnt == CW'(DW)) nxt = S_GAP;
            S_GAP:   if (gap_cnt == GW'(GAP_CYCLES - 1)) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Values for the output registers, i.e. what the pins show next cycle.
    always_comb begin
        pop       = 1'b0;
        data_nxt  = 1'b0;
        frame_nxt = 1'b0;
        unique case (state)
            S_IDLE: pop = (FIFO_LEVEL != '0);
            S_LOAD: begin
                frame_nxt = 1'b1;
                data_nxt  = rdata[DW-1];
            end
            S_SHIFT: begin
                if (bitcnt < CW'(DW - 1)) begin
                    frame_nxt = 1'b1;
                    data_nxt  = shreg[DW-1];
                end else if (bitcnt == CW'(DW - 1)) begin
                    frame_nxt = 1'b1;
                    data_nxt  = par;
                end
            end
            default: ;
        endcase
    end

endmodule
